// File: rtl/muldiv_unit_if.sv
// muldiv_unit_if: operation request, MTHI/MTLO write and result signals of muldiv_unit.
// master drives requests (controller side); slave is the unit itself.
interface muldiv_unit_if #(
  parameter int unsigned WIDTH = 32
);
  logic             start;
  logic [1:0]       op;
  logic [WIDTH-1:0] a;
  logic [WIDTH-1:0] b;
  logic             hi_we;
  logic             lo_we;
  logic [WIDTH-1:0] wdata;
  logic             busy;
  logic             done;
  logic             div_by_zero;
  logic [WIDTH-1:0] hi;
  logic [WIDTH-1:0] lo;

  modport master (
    output start, op, a, b, hi_we, lo_we, wdata,
    input  busy, done, div_by_zero, hi, lo
  );

  modport slave (
    input  start, op, a, b, hi_we, lo_we, wdata,
    output busy, done, div_by_zero, hi, lo
  );
endinterface

// File: rtl/muldiv_unit.sv
// muldiv_unit: iterative radix-2 multiply/divide with architectural HI/LO registers.
// Define MULDIV_DIV_EN to build the restoring divider; without it DIVU/DIV complete in one cycle with no effect.
module muldiv_unit #(
  parameter int unsigned WIDTH = 32
) (
  input logic          clk,
  input logic          reset,
  muldiv_unit_if.slave bus
);
  localparam int unsigned CW = $clog2(WIDTH + 1);

  typedef enum logic [1:0] {IDLE, RUN, FIX} state_t;
  state_t state, state_next;

  logic [CW-1:0]      count;
  logic [2*WIDTH-1:0] acc;
  logic [WIDTH-1:0]   mag_b;
  logic               is_div;
  logic               neg_res;
  logic [WIDTH-1:0]   hi_r, lo_r;
  logic               done_r, dbz_r;

  logic               sign_a, sign_b;
  logic [WIDTH-1:0]   a_mag, b_mag;
  logic [WIDTH:0]     mul_sum;
  logic [2*WIDTH-1:0] mul_next, mul_res;
`ifdef MULDIV_DIV_EN
  logic               neg_rem;
  logic               b_zero;
  logic [WIDTH-1:0]   a_orig;
  logic [WIDTH:0]     div_shift;
  logic [WIDTH-1:0]   div_diff, quo_res, rem_res;
  logic [2*WIDTH-1:0] div_next;
`endif

  always_comb begin
    sign_a   = bus.op[0] & bus.a[WIDTH-1];
    sign_b   = bus.op[0] & bus.b[WIDTH-1];
    a_mag    = sign_a ? -bus.a : bus.a;
    b_mag    = sign_b ? -bus.b : bus.b;
    // acc holds {partial product, unconsumed multiplier bits}
    mul_sum  = {1'b0, acc[2*WIDTH-1:WIDTH]} + {1'b0, mag_b & {WIDTH{acc[0]}}};
    mul_next = {mul_sum, acc[WIDTH-1:1]};
    mul_res  = neg_res ? -acc : acc;
`ifdef MULDIV_DIV_EN
    // acc holds {partial remainder, dividend bits / quotient bits}
    div_shift = {acc[2*WIDTH-1:WIDTH], acc[WIDTH-1]};
    div_diff  = div_shift[WIDTH-1:0] - mag_b;
    if (div_shift >= {1'b0, mag_b}) begin
      div_next = {div_diff, acc[WIDTH-2:0], 1'b1};
    end else begin
      div_next = {div_shift[WIDTH-1:0], acc[WIDTH-2:0], 1'b0};
    end
    quo_res = neg_res ? -acc[WIDTH-1:0] : acc[WIDTH-1:0];
    rem_res = neg_rem ? -acc[2*WIDTH-1:WIDTH] : acc[2*WIDTH-1:WIDTH];
`endif
  end

  always_comb begin
    state_next = state;
    case (state)
      IDLE: begin
        if (bus.start) begin
`ifdef MULDIV_DIV_EN
          state_next = RUN;
`else
          state_next = bus.op[1] ? FIX : RUN;
`endif
        end
      end
      RUN: begin
        if (count == CW'(1)) state_next = FIX;
      end
      FIX:     state_next = IDLE;
      default: state_next = IDLE;
    endcase
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) state <= IDLE;
    else       state <= state_next;
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      count   <= '0;
      acc     <= '0;
      mag_b   <= '0;
      is_div  <= 1'b0;
      neg_res <= 1'b0;
      hi_r    <= '0;
      lo_r    <= '0;
      done_r  <= 1'b0;
      dbz_r   <= 1'b0;
`ifdef MULDIV_DIV_EN
      neg_rem <= 1'b0;
      b_zero  <= 1'b0;
      a_orig  <= '0;
`endif
    end else begin
      done_r <= 1'b0;
      dbz_r  <= 1'b0;
      case (state)
        IDLE: begin
          if (bus.hi_we) hi_r <= bus.wdata;
          if (bus.lo_we) lo_r <= bus.wdata;
          if (bus.start) begin
            is_div  <= bus.op[1];
            neg_res <= sign_a ^ sign_b;
            acc     <= {{WIDTH{1'b0}}, a_mag};
            mag_b   <= b_mag;
            count   <= CW'(WIDTH);
`ifdef MULDIV_DIV_EN
            neg_rem <= sign_a;
            b_zero  <= (bus.b == '0);
            a_orig  <= bus.a;
`endif
          end
        end
        RUN: begin
          count <= count - CW'(1);
`ifdef MULDIV_DIV_EN
          acc <= is_div ? div_next : mul_next;
`else
          acc <= mul_next;
`endif
        end
        FIX: begin
          done_r <= 1'b1;
          if (!is_div) begin
            {hi_r, lo_r} <= mul_res;
          end
`ifdef MULDIV_DIV_EN
          else if (b_zero) begin
            // report the untouched dividend rather than the sign-corrected remainder
            hi_r  <= a_orig;
            lo_r  <= '1;
            dbz_r <= 1'b1;
          end else begin
            hi_r <= rem_res;
            lo_r <= quo_res;
          end
`endif
        end
        default: ;
      endcase
    end
  end

  assign bus.busy        = (state != IDLE);
  assign bus.done        = done_r;
  assign bus.div_by_zero = dbz_r;
  assign bus.hi          = hi_r;
  assign bus.lo          = lo_r;
endmodule

// File: tb/tb_muldiv_unit.sv
// tb_muldiv_unit: randomized scoreboard bench for muldiv_unit against an arithmetic reference model.
// Honours MULDIV_DIV_EN the same way as the design.
module tb_muldiv_unit;
  localparam int unsigned W = 32;
`ifdef MULDIV_DIV_EN
  localparam bit DIV_EN = 1'b1;
`else
  localparam bit DIV_EN = 1'b0;
`endif

  typedef struct {
    logic [W-1:0] hi;
    logic [W-1:0] lo;
    logic         dbz;
  } exp_t;

  logic clk = 1'b0;
  logic reset = 1'b1;
  int unsigned checks = 0;
  int unsigned errors = 0;
  exp_t sb[$];
  logic [W-1:0] m_hi = '0, m_lo = '0;
  logic [W-1:0] pre_hi = '0, pre_lo = '0;

  muldiv_unit_if #(.WIDTH(W)) bus ();

  muldiv_unit #(.WIDTH(W)) dut (
    .clk   (clk),
    .reset (reset),
    .bus   (bus)
  );

  always #5 clk = ~clk;

  function automatic void chk(input string name, input logic [2*W-1:0] act, input logic [2*W-1:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s actual=%0h expected=%0h", name, act, exp);
    end
  endfunction

  // Reference: plain wide/signed arithmetic on the architectural operands.
  function automatic exp_t model(input logic [1:0] o, input logic [W-1:0] x, input logic [W-1:0] y);
    exp_t e;
    logic [2*W-1:0] p;
    longint sx, sy;
    int qa, qb;
    e.hi = m_hi; e.lo = m_lo; e.dbz = 1'b0;
    case (o)
      2'b00: begin
        p = {{W{1'b0}}, x} * {{W{1'b0}}, y};
        {e.hi, e.lo} = p;
      end
      2'b01: begin
        sx = $signed(x); sy = $signed(y);
        p = sx * sy;
        {e.hi, e.lo} = p;
      end
      default: begin
`ifdef MULDIV_DIV_EN
        if (y == '0) begin
          e.lo = '1; e.hi = x; e.dbz = 1'b1;
        end else if (o == 2'b10) begin
          e.lo = x / y; e.hi = x % y;
        end else if (x == 32'h8000_0000 && y == 32'hFFFF_FFFF) begin
          e.lo = 32'h8000_0000; e.hi = '0;
        end else begin
          qa = $signed(x); qb = $signed(y);
          e.lo = qa / qb; e.hi = qa % qb;
        end
`endif
      end
    endcase
    return e;
  endfunction

  task automatic step();
    @(posedge clk); #1;
  endtask

  task automatic idle_inputs();
    bus.start = 1'b0; bus.hi_we = 1'b0; bus.lo_we = 1'b0;
  endtask

  task automatic junk_inputs();
    bus.start = 1'($urandom); bus.op = 2'($urandom); bus.a = $urandom; bus.b = $urandom;
    bus.hi_we = 1'($urandom); bus.lo_we = 1'($urandom); bus.wdata = $urandom;
  endtask

  // Call only while the unit is idle (or in its done cycle), #1 after an edge.
  task automatic start_op(input logic [1:0] o, input logic [W-1:0] xa, input logic [W-1:0] xb,
                          input logic whi, input logic wlo, input logic [W-1:0] wd);
    exp_t e;
    bus.start = 1'b1; bus.op = o; bus.a = xa; bus.b = xb;
    bus.hi_we = whi; bus.lo_we = wlo; bus.wdata = wd;
    if (whi) m_hi = wd;
    if (wlo) m_lo = wd;
    e = model(o, xa, xb);
    sb.push_back(e);
    pre_hi = m_hi; pre_lo = m_lo;
    m_hi = e.hi; m_lo = e.lo;
    step();
  endtask

  task automatic wait_done(input logic [1:0] o, input bit force10);
    int unsigned n, busy_n, lat;
    lat = (o[1] && !DIV_EN) ? 1 : W + 1;
    n = 0; busy_n = 0;
    while (!bus.done && n < 200) begin
      if (bus.busy) begin
        busy_n++;
        junk_inputs();
        if (force10 && n == 10) begin
          bus.start = 1'b1; bus.op = 2'b10; bus.hi_we = 1'b1; bus.wdata = 32'h1234;
        end
      end else begin
        idle_inputs();
      end
      chk("hold_hilo", {bus.hi, bus.lo}, {pre_hi, pre_lo});
      step();
      n++;
    end
    idle_inputs();
    chk("latency", n, lat);
    chk("busy_cycles", busy_n, lat);
  endtask

  task automatic mt_write(input logic whi, input logic wlo, input logic [W-1:0] wd);
    bus.hi_we = whi; bus.lo_we = wlo; bus.wdata = wd;
    if (whi) m_hi = wd;
    if (wlo) m_lo = wd;
    step();
    idle_inputs();
    chk("mt_hi", bus.hi, m_hi);
    chk("mt_lo", bus.lo, m_lo);
  endtask

  // Monitor: every done pulse must match the oldest outstanding expectation.
  initial begin
    exp_t e;
    forever begin
      @(negedge clk);
      if (!reset && bus.done) begin
        if (sb.size() == 0) begin
          checks++; errors++;
          $display("FAIL unexpected_done actual=1 expected=0");
        end else begin
          e = sb.pop_front();
          chk("res_hi", bus.hi, e.hi);
          chk("res_lo", bus.lo, e.lo);
          chk("res_dbz", bus.div_by_zero, e.dbz);
        end
      end
    end
  end

  initial begin
    logic [1:0] o;
    logic [W-1:0] xa, xb, wd;
    logic whi, wlo;
    bus.start = 1'b0; bus.op = '0; bus.a = '0; bus.b = '0;
    bus.hi_we = 1'b0; bus.lo_we = 1'b0; bus.wdata = '0;
    #3;
    chk("rst_hi", bus.hi, 0);
    chk("rst_lo", bus.lo, 0);
    chk("rst_busy", bus.busy, 0);
    chk("rst_done", bus.done, 0);
    chk("rst_dbz", bus.div_by_zero, 0);
    step();
    reset = 1'b0;
    step();

    start_op(2'b00, 32'hFFFF_FFFF, 32'hFFFF_FFFF, 1'b0, 1'b0, '0);
    wait_done(2'b00, 1'b0);
    chk("multu_max", {bus.hi, bus.lo}, 64'hFFFF_FFFE_0000_0001);
    start_op(2'b01, 32'hFFFF_FFFD, 32'h0000_0005, 1'b0, 1'b0, '0);
    wait_done(2'b01, 1'b0);
    chk("mult_neg", {bus.hi, bus.lo}, 64'hFFFF_FFFF_FFFF_FFF1);
    start_op(2'b00, 32'hFFFF_FFFD, 32'h0000_0005, 1'b0, 1'b0, '0);
    wait_done(2'b00, 1'b0);
    chk("multu_same", {bus.hi, bus.lo}, 64'h0000_0004_FFFF_FFF1);
    start_op(2'b11, 32'hFFFF_FFF9, 32'h0000_0002, 1'b0, 1'b0, '0);
    wait_done(2'b11, 1'b0);
`ifdef MULDIV_DIV_EN
    chk("div_neg", {bus.hi, bus.lo}, 64'hFFFF_FFFF_FFFF_FFFD);
`endif
    start_op(2'b11, 32'h8000_0000, 32'hFFFF_FFFF, 1'b0, 1'b0, '0);
    wait_done(2'b11, 1'b0);
`ifdef MULDIV_DIV_EN
    chk("div_ovf", {bus.hi, bus.lo}, 64'h0000_0000_8000_0000);
`endif
    start_op(2'b10, 32'h0000_0064, 32'h0, 1'b0, 1'b0, '0);
    wait_done(2'b10, 1'b0);
    start_op(2'b00, 32'h0000_0003, 32'h0000_0004, 1'b0, 1'b0, '0);
    wait_done(2'b00, 1'b1);
    chk("multu_3x4", {bus.hi, bus.lo}, 64'h0000_0000_0000_000C);
    mt_write(1'b0, 1'b1, 32'h55);
    chk("mtlo_55", bus.lo, 32'h55);

    // Abort a MULT with reset at cycle 15.
    start_op(2'b01, 32'h1234_5678, 32'hFEDC_BA98, 1'b0, 1'b0, '0);
    for (int i = 0; i < 14; i++) begin
      junk_inputs();
      step();
    end
    idle_inputs();
    reset = 1'b1;
    #2;
    sb.delete();
    m_hi = '0; m_lo = '0;
    chk("abort_hi", bus.hi, 0);
    chk("abort_lo", bus.lo, 0);
    chk("abort_busy", bus.busy, 0);
    chk("abort_done", bus.done, 0);
    step();
    reset = 1'b0;
    step();
    chk("post_rst_done", bus.done, 0);
    start_op(2'b01, 32'hFFFF_FFF0, 32'h0000_0010, 1'b0, 1'b0, '0);
    wait_done(2'b01, 1'b0);

    for (int i = 0; i < 40; i++) begin
      o = 2'($urandom_range(0, 3));
      xa = $urandom; xb = $urandom;
      case ($urandom_range(0, 7))
        0: xb = '0;
        1: begin xa = 32'h8000_0000; xb = '1; end
        2: begin xa = $urandom_range(0, 50); xb = $urandom_range(1, 9); end
        3: begin xa = -$urandom_range(0, 50); xb = -$urandom_range(1, 9); end
        default: ;
      endcase
      if ($urandom_range(0, 3) == 0) begin
        mt_write(1'($urandom), 1'b1, $urandom);
      end
      whi = ($urandom_range(0, 4) == 0);
      wlo = ($urandom_range(0, 4) == 0);
      wd = $urandom;
      start_op(o, xa, xb, whi, wlo, wd);
      wait_done(o, 1'b0);
    end

    step();
    @(negedge clk);
    chk("sb_drained", sb.size(), 0);
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end
endmodule
